// File: rtl/instr_exec_sequencer.sv
// ---------------------------------------------------------------------------
// instr_register_pkg
//   Shared types for the instruction register and its consumers.
//   An instruction word is {opc, op_a, op_b}; operands are signed 32-bit.
// ---------------------------------------------------------------------------
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// ---------------------------------------------------------------------------
// instr_exec_sequencer
//   Walks a contiguous range of instruction-register locations, executes
//   each opcode on its two operands and streams the results out on a
//   valid/ready interface.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle request, honoured only when idle
//   start_addr        : first location to execute
//   num_instr         : number of locations to execute (0 = no reads)
//   read_pointer      : read address into the instruction register
//   instruction_word  : combinational read data for read_pointer
//   busy              : high whenever the sequencer is not idle
//   done              : one-cycle pulse when the sequence completes
//   res_valid/ready   : result handshake
//   res_data          : signed result (full width, sign-extended)
//   res_opcode        : opcode that produced res_data
//   res_addr          : location that was executed
//   res_div0          : DIV/MOD attempted with op_b == 0
// ---------------------------------------------------------------------------
module instr_exec_sequencer
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RES_W  = 64    // must be >= 64 to hold the full product
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [ADDR_W:0]         num_instr,
    output logic [ADDR_W-1:0]       read_pointer,
    input  instruction_t            instruction_word,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output opcode_t                 res_opcode,
    output logic [ADDR_W-1:0]       res_addr,
    output logic                    res_div0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     remaining;

    // -----------------------------------------------------------------------
    // Execute unit. Operands are widened to RES_W before any arithmetic so
    // ADD/SUB cannot overflow, MULT yields the full signed product and
    // DIV of -2**31 by -1 gives +2**31 instead of wrapping.
    // -----------------------------------------------------------------------
    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] alu_res;
    logic                    alu_div0;

    always_comb begin
        a_ext    = {{(RES_W-32){instruction_word.op_a[31]}}, instruction_word.op_a};
        b_ext    = {{(RES_W-32){instruction_word.op_b[31]}}, instruction_word.op_b};
        alu_res  = '0;
        alu_div0 = 1'b0;
        case (instruction_word.opc)
            ZERO:  alu_res = '0;
            PASSA: alu_res = a_ext;
            PASSB: alu_res = b_ext;
            ADD:   alu_res = a_ext + b_ext;
            SUB:   alu_res = a_ext - b_ext;
            MULT:  alu_res = a_ext * b_ext;
            // Signed / truncates toward zero and % takes the dividend's
            // sign, which is exactly the required semantics.
            DIV: begin
                if (b_ext == '0) alu_div0 = 1'b1;
                else             alu_res  = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) alu_div0 = 1'b1;
                else             alu_res  = a_ext % b_ext;
            end
            default: alu_res = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM. All outputs are registered; busy and done are updated
    // on the same edges that change state so they track it exactly.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            read_pointer <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_opcode   <= ZERO;
            res_addr     <= '0;
            res_div0     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_instr != '0) begin
                            read_pointer <= start_addr;
                            remaining    <= num_instr;
                            state        <= FETCH;
                        end else begin
                            // Empty request: complete without touching
                            // the register.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                // read_pointer has been stable for this whole cycle, so the
                // combinational read data is valid at the closing edge.
                FETCH: begin
                    res_data   <= alu_res;
                    res_opcode <= instruction_word.opc;
                    res_div0   <= alu_div0;
                    res_addr   <= read_pointer;
                    res_valid  <= 1'b1;
                    state      <= OUT;
                end

                // res_* are only written in FETCH, so they hold here until
                // the consumer accepts.
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        remaining <= remaining - (ADDR_W+1)'(1);
                        if (remaining == (ADDR_W+1)'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Natural wrap past the top location.
                            read_pointer <= read_pointer + ADDR_W'(1);
                            state        <= FETCH;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
